// File: rtl/slurm16_memory_arbiter_pkg.sv
// slurm16_memory_arbiter_pkg: shared slurm16 CPU constants and arbiter owner encoding
package slurm16_memory_arbiter_pkg;
  localparam int CPU_BITS = 16;
  localparam int CPU_ADDRESS_BITS = 16;
  localparam int MAX_BURST_DEFAULT = 16;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OWN_CPU = 2'd1,
    OWN_DMA = 2'd2
  } owner_t;
endpackage

// File: rtl/slurm16_memory_arbiter_if.sv
// slurm16_memory_arbiter_if: CPU/DMA request handshakes and the single-port RAM request bus
interface slurm16_memory_arbiter_if
  import slurm16_memory_arbiter_pkg::*;
#(
  parameter int BITS = CPU_BITS,
  parameter int ADDRESS_BITS = CPU_ADDRESS_BITS
);
  logic [ADDRESS_BITS-1:0] cpu_address, dma_address, ram_address;
  logic [BITS-1:0] cpu_out, cpu_in, dma_out, dma_in, ram_wdata, ram_rdata;
  logic cpu_valid, cpu_wr, cpu_ready, dma_valid, dma_wr, dma_ready, ram_wr;
  logic [1:0] cpu_wr_mask, dma_wr_mask, ram_wr_mask;
  modport slave (
    input cpu_address, cpu_out, cpu_valid, cpu_wr, cpu_wr_mask,
    input dma_address, dma_out, dma_valid, dma_wr, dma_wr_mask, ram_rdata,
    output cpu_ready, cpu_in, dma_ready, dma_in,
    output ram_address, ram_wdata, ram_wr_mask, ram_wr
  );
  modport master (
    output cpu_address, cpu_out, cpu_valid, cpu_wr, cpu_wr_mask,
    output dma_address, dma_out, dma_valid, dma_wr, dma_wr_mask, ram_rdata,
    input cpu_ready, cpu_in, dma_ready, dma_in,
    input ram_address, ram_wdata, ram_wr_mask, ram_wr
  );
endinterface

// File: rtl/slurm16_burst_counter.sv
// slurm16_burst_counter: saturating count of accepted transfers for the current owner
module slurm16_burst_counter #(
  parameter int MAX_BURST = 16
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic inc,
  output logic at_limit
);
  localparam int W = $clog2(MAX_BURST) + 1;
  logic [W-1:0] count;
  always_ff @(posedge CLK or posedge RST)
    if (RST) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != W'(MAX_BURST)) count <= count + 1'b1;
  // high when the next accepted transfer reaches (or stays at) the limit
  assign at_limit = count >= W'(MAX_BURST - 1);
endmodule

// File: rtl/slurm16_memory_arbiter.sv
// slurm16_memory_arbiter: CPU/DMA arbiter in front of one single-port RAM with burst fairness
module slurm16_memory_arbiter
  import slurm16_memory_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEFAULT
) (
  input logic CLK,
  input logic RST,
  slurm16_memory_arbiter_if.slave bus
);
  owner_t state, next;
  logic hold, cpu_rdy, dma_rdy, sel_dma, at_limit;
  // hold blocks the first cycle after a burst-limit handover so the RAM sees one idle cycle
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      hold <= 1'b0;
    end else begin
      state <= next;
      hold <= (cpu_rdy || dma_rdy) && next != state;
    end
  always_comb
    next = state == IDLE ? (bus.cpu_valid ? OWN_CPU : bus.dma_valid ? OWN_DMA : IDLE)
         : state == OWN_CPU ? (!bus.cpu_valid ? (bus.dma_valid ? OWN_DMA : IDLE)
                               : (cpu_rdy && at_limit && bus.dma_valid) ? OWN_DMA : OWN_CPU)
         : (!bus.dma_valid ? (bus.cpu_valid ? OWN_CPU : IDLE)
            : (dma_rdy && at_limit && bus.cpu_valid) ? OWN_CPU : OWN_DMA);
  always_comb begin
    sel_dma = state == OWN_DMA;
    cpu_rdy = state == OWN_CPU && !hold && bus.cpu_valid;
    dma_rdy = sel_dma && !hold && bus.dma_valid;
    bus.cpu_ready = cpu_rdy;
    bus.dma_ready = dma_rdy;
    bus.ram_address = sel_dma ? bus.dma_address : bus.cpu_address;
    bus.ram_wdata = sel_dma ? bus.dma_out : bus.cpu_out;
    bus.ram_wr_mask = sel_dma ? bus.dma_wr_mask : bus.cpu_wr_mask;
    bus.ram_wr = sel_dma ? dma_rdy && bus.dma_wr : cpu_rdy && bus.cpu_wr;
    bus.cpu_in = bus.ram_rdata;
    bus.dma_in = bus.ram_rdata;
  end
  slurm16_burst_counter #(.MAX_BURST(MAX_BURST)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .clear(next != state),
    .inc(cpu_rdy || dma_rdy),
    .at_limit(at_limit)
  );
endmodule

// File: tb/tb_slurm16_memory_arbiter.sv
// tb_slurm16_memory_arbiter: directed and random checks of the arbiter against a behavioural model
module tb_slurm16_memory_arbiter;
  import slurm16_memory_arbiter_pkg::*;
  localparam int MAXB = 16;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int passed = 0;
  int total = 0;
  always #5 CLK = ~CLK;
  slurm16_memory_arbiter_if bus ();
  slurm16_memory_arbiter #(.MAX_BURST(MAXB)) dut (.CLK(CLK), .RST(RST), .bus(bus.slave));

  function automatic logic [15:0] init_val(input logic [15:0] a);
    return 16'(a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // RAM environment: one-cycle read latency, byte-lane masked writes
  logic [15:0] ram [0:65535];
  bit seen [0:65535];
  always @(posedge CLK) begin
    if (bus.ram_wr) begin
      ram[bus.ram_address] <= {bus.ram_wr_mask[1] ? bus.ram_wdata[15:8] : (seen[bus.ram_address] ? ram[bus.ram_address][15:8] : init_val(bus.ram_address)[15:8]),
                               bus.ram_wr_mask[0] ? bus.ram_wdata[7:0] : (seen[bus.ram_address] ? ram[bus.ram_address][7:0] : init_val(bus.ram_address)[7:0])};
      seen[bus.ram_address] <= 1'b1;
    end
    bus.ram_rdata <= seen[bus.ram_address] ? ram[bus.ram_address] : init_val(bus.ram_address);
  end

  // reference model: owner 0=none 1=cpu 2=dma, run=accepted transfers of this owner
  logic [15:0] shadow [0:65535];
  int owner, run;
  bit gap, pend, last_gc, last_gd;
  logic [15:0] pend_data;

  task automatic model_reset();
    owner = 0; run = 0; gap = 0; pend = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit cv, input bit cw, input logic [1:0] cm, input logic [15:0] ca, input logic [15:0] cd,
                       input bit dv, input bit dw, input logic [1:0] dm, input logic [15:0] da, input logic [15:0] dd);
    bit gc, gd, mine, other, lim;
    int nxt;
    logic [15:0] a, d;
    logic [1:0] m;
    bus.cpu_valid = cv; bus.cpu_wr = cw; bus.cpu_wr_mask = cm; bus.cpu_address = ca; bus.cpu_out = cd;
    bus.dma_valid = dv; bus.dma_wr = dw; bus.dma_wr_mask = dm; bus.dma_address = da; bus.dma_out = dd;
    @(negedge CLK);
    gc = owner == 1 && !gap && cv;
    gd = owner == 2 && !gap && dv;
    a = owner == 2 ? da : ca;
    d = owner == 2 ? dd : cd;
    m = owner == 2 ? dm : cm;
    chk("cpu_ready", 32'(bus.cpu_ready), 32'(gc));
    chk("dma_ready", 32'(bus.dma_ready), 32'(gd));
    chk("ram_wr", 32'(bus.ram_wr), 32'((gc && cw) || (gd && dw)));
    chk("ram_address", 32'(bus.ram_address), 32'(a));
    if (gc || gd) begin
      chk("ram_wdata", 32'(bus.ram_wdata), 32'(d));
      chk("ram_wr_mask", 32'(bus.ram_wr_mask), 32'(m));
    end
    if (pend) begin
      chk("cpu_in", 32'(bus.cpu_in), 32'(pend_data));
      chk("dma_in", 32'(bus.dma_in), 32'(pend_data));
    end
    chk("burst_count", 32'(dut.u_cnt.count), 32'(run));
    pend = (gc && !cw) || (gd && !dw);
    pend_data = shadow[a];
    if ((gc && cw) || (gd && dw)) begin
      if (m[0]) shadow[a][7:0] = d[7:0];
      if (m[1]) shadow[a][15:8] = d[15:8];
    end
    mine = owner == 1 ? cv : dv;
    other = owner == 1 ? dv : cv;
    lim = (gc || gd) && run + 1 >= MAXB && other;
    nxt = owner == 0 ? (cv ? 1 : dv ? 2 : 0) : !mine ? (other ? 3 - owner : 0) : lim ? 3 - owner : owner;
    gap = lim;
    run = nxt != owner ? 0 : (gc || gd) ? (run < MAXB ? run + 1 : MAXB) : run;
    owner = nxt;
    last_gc = gc;
    last_gd = gd;
    @(posedge CLK);
    #1;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    cycle(1, 0, 2'b00, a, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
  endtask

  task automatic idle();
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 0, 0, 2'b00, 16'h0, 16'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    bus.cpu_valid = 1; bus.dma_valid = 1; bus.cpu_wr = 1; bus.dma_wr = 1;
    bus.cpu_wr_mask = 2'b11; bus.dma_wr_mask = 2'b11;
    bus.cpu_address = 16'h0; bus.dma_address = 16'h0; bus.cpu_out = 16'h0; bus.dma_out = 16'h0;
    #2;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst_dma_ready", 32'(bus.dma_ready), 32'd0);
    chk("rst_ram_wr", 32'(bus.ram_wr), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_count", 32'(dut.u_cnt.count), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    int first, ng;
    for (int i = 0; i < 65536; i++) shadow[i] = init_val(16'(i));
    model_reset();
    do_reset();
    // lone CPU read of 0x1234
    cpu_rd(16'h1234);
    cpu_rd(16'h1234);
    idle();
    // both request from IDLE: 16 CPU transfers, one idle cycle, then DMA
    do_reset();
    first = -1; ng = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1, 0, 2'b00, 16'($urandom), 16'h0, 1, 0, 2'b00, 16'($urandom), 16'h0);
      ng += int'(last_gc);
      if (last_gd && first < 0) first = i;
    end
    chk("B_cpu_grants", 32'(ng), 32'd16);
    chk("B_first_dma_cycle", 32'(first), 32'd18);
    // DMA masked write then CPU readback
    do_reset();
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 1, 1, 2'b10, 16'h0040, 16'hBEEF);
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 1, 1, 2'b10, 16'h0040, 16'hBEEF);
    cpu_rd(16'h0040);
    cpu_rd(16'h0040);
    idle();
    chk("C_shadow_hi", 32'(shadow[16'h0040][15:8]), 32'h0BE);
    // CPU streams 40 reads with DMA idle
    do_reset();
    ng = 0;
    for (int i = 0; i < 40; i++) begin
      cpu_rd(16'($urandom));
      ng += int'(last_gc);
    end
    chk("D_cpu_grants", 32'(ng), 32'd39);
    chk("D_count_sat", 32'(dut.u_cnt.count), 32'd16);
    // reset on the 5th of 10 CPU writes
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 1, 2'b11, 16'($urandom), 16'($urandom), 0, 0, 2'b00, 16'h0, 16'h0);
    bus.cpu_valid = 1; bus.cpu_wr = 1; bus.cpu_address = 16'h0777; bus.cpu_out = 16'h1111;
    #2;
    chk("E_ready_pre", 32'(bus.cpu_ready), 32'd1);
    RST = 1'b1;
    #1;
    chk("E_cpu_ready_rst", 32'(bus.cpu_ready), 32'd0);
    chk("E_ram_wr_rst", 32'(bus.ram_wr), 32'd0);
    chk("E_dma_ready_rst", 32'(bus.dma_ready), 32'd0);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    model_reset();
    chk("E_state_idle", 32'(dut.state), 32'(IDLE));
    cpu_rd(16'h0777);
    cpu_rd(16'h0777);
    idle();
    // cpu_valid drops while DMA waits
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 0, 2'b00, 16'($urandom), 16'h0, 1, 0, 2'b00, 16'h0100, 16'h0);
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 2'b00, 16'h0100, 16'h0);
    chk("F_state_dma", 32'(dut.state), 32'(OWN_DMA));
    chk("F_count_zero", 32'(dut.u_cnt.count), 32'd0);
    cycle(0, 0, 2'b00, 16'h0, 16'h0, 1, 0, 2'b00, 16'h0100, 16'h0);
    idle();
    // random traffic, small address window so reads hit earlier writes
    do_reset();
    for (int i = 0; i < 500; i++)
      cycle($urandom_range(0, 4) != 0, 1'($urandom), 2'($urandom), 16'($urandom_range(0, 15)), 16'($urandom),
            $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom), 16'($urandom_range(0, 15)), 16'($urandom));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
